// File: rtl/uart_mmio_core.sv
// Memory-mapped 8N1 UART: TX shifter, RX deserialiser and a polled receive buffer.
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise a single holding register.
module uart_mmio_core #(
    parameter int CLK_DIV  = 16,
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rd,
    input  logic       uart_wr,
    input  logic       uart_addr,
    input  logic [7:0] uart_din,
    output logic [7:0] uart_dout,
    input  logic       rxd,
    output logic       txd
);
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = RX_DEPTH;
`else
    localparam int DEPTH = (RX_DEPTH > 0) ? 1 : 1;
`endif
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [DW-1:0]   tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic [2:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic            txd_q, txd_d;
    logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic            rx_push_q, rx_push_d, frame_set;
    logic            frame_err_q, frame_err_d, rx_ovr_q, rx_ovr_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      dout_q, dout_d, status;
    logic            pop, push_ok, ovr_set, stat_clr, full;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        if (tx_state_q == S_IDLE) begin
            txd_d = 1'b1;
            if (uart_wr && !uart_addr) begin
                tx_state_d = S_START;
                tx_div_d   = '0;
                tx_shift_d = uart_din;
                txd_d      = 1'b0;
            end
        end else if (tx_div_q == DIV_LAST) begin
            tx_div_d = '0;
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
                default: begin
                    tx_state_d = S_IDLE;
                    txd_d      = 1'b1;
                end
            endcase
        end else begin
            tx_div_d = tx_div_q + 1'b1;
        end
    end

    // RX decisions use the synchronised line; a falling edge is s2 low after prev high.
    always_comb begin
        rx_s1_d    = rxd;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_d  = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_div_d   = '0;
                end
            end
            S_START: begin
                if (rx_div_q == HALF_LAST) begin
                    rx_div_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_div_d = rx_div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_div_q == DIV_LAST) begin
                    rx_div_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_div_d = rx_div_q + 1'b1;
                end
            end
            default: begin
                if (rx_div_q == DIV_LAST) begin
                    rx_state_d = S_IDLE;
                    rx_push_d  = rx_s2_q;
                    frame_set  = !rx_s2_q;
                end else begin
                    rx_div_d = rx_div_q + 1'b1;
                end
            end
        endcase
    end

    // A pop frees the head slot on the same edge, so a push into a full buffer still fits.
    always_comb begin
        status   = {4'b0, frame_err_q, rx_ovr_q, (count_q != '0), (tx_state_q == S_IDLE)};
        full     = (count_q == CW'(DEPTH));
        pop      = uart_rd && !uart_addr && (count_q != '0);
        push_ok  = rx_push_q && (!full || pop);
        ovr_set  = rx_push_q && full && !pop;
        stat_clr = uart_rd && uart_addr;
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = rx_shift_q;
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
        frame_err_d = (frame_err_q && !stat_clr) || frame_set;
        rx_ovr_d    = (rx_ovr_q && !stat_clr) || ovr_set;
        dout_d = dout_q;
        if (uart_rd) begin
            if (uart_addr)            dout_d = status;
            else if (count_q != '0)   dout_d = mem_q[rd_ptr_q];
            else                      dout_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_div_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_push_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_ovr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= 8'h00;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_div_q    <= rx_div_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_push_q   <= rx_push_d;
            frame_err_q <= frame_err_d;
            rx_ovr_q    <= rx_ovr_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
        end
    end

    assign txd       = txd_q;
    assign uart_dout = dout_q;
endmodule

// File: tb/tb_uart_mmio_core.sv
// Directed bench for uart_mmio_core at CLK_DIV=16; all stimulus and sampling on the falling edge.
module tb_uart_mmio_core;
    localparam int CLK_DIV = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, uart_rd, uart_wr, uart_addr, rxd;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       txd;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_mmio_core #(.CLK_DIV(CLK_DIV), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .uart_rd(uart_rd), .uart_wr(uart_wr),
        .uart_addr(uart_addr), .uart_din(uart_din), .uart_dout(uart_dout),
        .rxd(rxd), .txd(txd)
    );

    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d, output int edge_n);
        uart_wr = 1'b1; uart_addr = a; uart_din = d;
        edge_n = cyc + 1;
        @(negedge clk);
        uart_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        uart_rd = 1'b1; uart_addr = a;
        @(negedge clk);
        uart_rd = 1'b0;
        d = uart_dout;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (uart_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", uart_dout); end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL reset_status: got %h want 01", d); end
    endtask

    task automatic test_tx();
        logic [9:0] frame;
        logic [7:0] s0, s1;
        int         n, dummy, lows;
        frame = {1'b1, 8'hA5, 1'b0};
        cpu_write(1'b0, 8'hA5, n);
        for (int b = 0; b < 10; b++) begin
            wait_until(n + 8 + 16 * b);
            n_cmp++;
            if (txd !== frame[b]) begin n_fail++; $display("FAIL tx_bit%0d: got %b want %b", b, txd, frame[b]); end
            if (b == 3) cpu_write(1'b0, 8'h0F, dummy);
        end
        wait_until(n + 159);
        uart_rd = 1'b1; uart_addr = 1'b1;
        @(negedge clk);
        s0 = uart_dout;
        @(negedge clk);
        uart_rd = 1'b0;
        s1 = uart_dout;
        n_cmp++; if (s0 !== 8'h00) begin n_fail++; $display("FAIL tx_busy_last: got %h want 00", s0); end
        n_cmp++; if (s1 !== 8'h01) begin n_fail++; $display("FAIL tx_ready_after: got %h want 01", s1); end
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd === 1'b0) lows++;
        end
        n_cmp++; if (lows !== 0) begin n_fail++; $display("FAIL tx_no_extra_frame: got %0d low cycles want 0", lows); end
    endtask

    task automatic test_rx_single();
        logic [7:0] d;
        int         n;
        send_rx(8'h3C, 1'b1);
        cpu_write(1'b0, 8'h00, n);
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h02) begin n_fail++; $display("FAIL rx_status: got %h want 02", d); end
        cpu_read(1'b0, d);
        n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL rx_data: got %h want 3c", d); end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL rx_status_after: got %h want 00", d); end
        wait_until(n + 165);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, exp;
        int         n;
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        cpu_write(1'b0, 8'h00, n);
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h06) begin n_fail++; $display("FAIL b2b_status: got %h want 06", d); end
        for (int i = 0; i <= DEPTH; i++) begin
            exp = (i < DEPTH) ? 8'(i + 1) : 8'h00;
            cpu_read(1'b0, d);
            n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL b2b_read%0d: got %h want %h", i, d, exp); end
        end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL b2b_status_empty: got %h want 00", d); end
        wait_until(n + 165);
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        int         n;
        send_rx(8'h55, 1'b0);
        cpu_write(1'b0, 8'h00, n);
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL ferr_status: got %h want 08", d); end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL ferr_cleared: got %h want 00", d); end
        wait_until(n + 165);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL glitch_status: got %h want 01", d); end
        cpu_read(1'b0, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL glitch_data: got %h want 00", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        int         n;
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL pre_rst_status: got %h want 01", d); end
        send_rx(8'hAA, 1'b0);
        cpu_write(1'b0, 8'hA5, n);
        wait_until(n + 49);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd: got %b want 1", txd); end
        n_cmp++; if (uart_dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h want 00", uart_dout); end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL rst_status: got %h want 01", d); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d, exp;
        int         s;
        for (int i = 0; i < DEPTH; i++) send_rx(8'h10 + 8'(i), 1'b1);
        s = cyc;
        fork
            send_rx(8'h99, 1'b1);
            begin
                wait_until(s + 155);
                cpu_read(1'b0, d);
            end
        join
        n_cmp++; if (d !== 8'h10) begin n_fail++; $display("FAIL full_pop_data: got %h want 10", d); end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h03) begin n_fail++; $display("FAIL full_status: got %h want 03", d); end
        for (int i = 1; i <= DEPTH; i++) begin
            exp = (i < DEPTH) ? 8'h10 + 8'(i) : 8'h99;
            cpu_read(1'b0, d);
            n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL full_read%0d: got %h want %h", i, d, exp); end
        end
        cpu_read(1'b1, d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL full_status_empty: got %h want 01", d); end
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; uart_rd = 1'b0; uart_wr = 1'b0; uart_addr = 1'b0;
        uart_din = 8'h00; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_tx();
        test_rx_single();
        test_back_to_back();
        test_frame_err();
        test_reset_mid_tx();
        test_full_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
